hsv_core_alu_issue_arbiter: RTL
===============================

Name: hsv_core_alu_issue_arbiter

Overview:
Shares the single ALU execution unit between N_REQ issue requesters, for example a primary issue port and a replay/secondary port, using round-robin arbitration with grant locking. Tracks ALU in-flight occupancy and throttles issue at MAX_INFLIGHT. Sequences flush: blocks issue, forwards the flush to the ALU, waits for the ALU ack, then acks upstream. Sits between the issue stage and the ALU input channel, and observes the ALU commit handshake.

Parameters:
N_REQ, 2, number of requesters (>=2)
MAX_INFLIGHT, 4, max accepted-but-not-committed ALU ops (ALU pipe depth + skid)

Ports:
clk_core  in  1  core clock
rst_core  in  1  synchronous, active-high reset
flush_req  in  1  upstream flush request (level)
flush_ack  out  1  upstream flush acknowledge
req_data  in  N_REQ x $bits(alu_data_t)  per-requester ALU op
req_valid  in  N_REQ  per-requester valid
req_ready  out  N_REQ  per-requester ready
alu_data  out  $bits(alu_data_t)  op to ALU in_alu_data
alu_valid  out  1  to ALU in_valid
alu_ready  in  1  from ALU in_ready
alu_flush_req  out  1  to ALU flush_req
alu_flush_ack  in  1  from ALU flush_ack
commit_fire  in  1  ALU out_valid & out_ready (one op retired)
grant_id  out  $clog2(N_REQ)  index of the current grant (valid when alu_valid)
inflight  out  $clog2(MAX_INFLIGHT+1)  current occupancy count

Behaviour:
- All state is updated on posedge clk_core. rst_core=1 at a clock edge sets state=RUN, rr_ptr=0, lock=0, inflight=0. After reset: flush_ack=0, alu_flush_req=0, alu_valid=0, all req_ready=0 until the next combinational evaluation in RUN.
- FSM states: RUN, FLUSH_WAIT, FLUSH_DONE.
- RUN, issue path, zero latency (combinational):
  - can_issue = (inflight < MAX_INFLIGHT).
  - If lock=1, the grant is locked_id. Otherwise the grant is the first requester with req_valid set, searching from rr_ptr upward with wrap.
  - alu_valid = can_issue & req_valid[grant].
  - alu_data = req_data[grant].
  - req_ready[grant] = can_issue & alu_ready. All other req_ready are 0.
- Accept is alu_valid & alu_ready. On accept: rr_ptr <= (grant+1) mod N_REQ, lock <= 0.
- If alu_valid & ~alu_ready: lock <= 1 and locked_id <= grant. This keeps alu_data/alu_valid stable until accept, per handshake rules. A newly valid higher-priority requester never steals a locked grant.
- inflight: +1 on accept, -1 on commit_fire. Both in the same cycle leaves it unchanged. commit_fire with inflight=0 is illegal (assertion). inflight never exceeds MAX_INFLIGHT.
- RUN -> FLUSH_WAIT when flush_req=1. flush_req takes priority over any same-cycle accept: in the cycle flush_req is seen, alu_valid=0 and all req_ready=0.
- FLUSH_WAIT:
  - alu_flush_req=1, alu_valid=0, req_ready=0, lock <= 0.
  - Stay here until alu_flush_ack=1, then go to FLUSH_DONE.
  - The flush is not abortable: if flush_req drops, remain in FLUSH_WAIT until the ack.
- FLUSH_DONE:
  - flush_ack=1, alu_flush_req=1 while flush_req=1.
  - inflight <= 0, rr_ptr <= 0.
  - -> RUN when flush_req=0. flush_ack and alu_flush_req deassert in that cycle.
- commit_fire during FLUSH_* is ignored (the count is cleared anyway).
- A dropped alu_valid under flush is an allowed handshake exception.
- Reset mid-flush returns to RUN with all outputs deasserted.

Decomposition:
- hsv_core_pkg gains:
  - typedef alu_arb_state_t {RUN, FLUSH_WAIT, FLUSH_DONE}
  - localparam ALU_MAX_INFLIGHT=4
  - alu_data_t is reused unchanged.
- One sub-module: hsv_core_rr_pick (parameter N; inputs req vector and ptr; outputs grant index and any). It is pure combinational and reusable by future LSU/branch arbiters.

Test Plan:
- Both req_valid=1 continuously, alu_ready=1, N_REQ=2 -> grant_id alternates 0,1,0,1. Each requester gets one accept per 2 cycles. Requests stay blocked once inflight reaches 4 with no commit_fire.
- req0 valid, alu_ready=0 for 3 cycles while req1 rises in cycle 1 -> grant_id stays 0 and alu_data stays stable. Accept occurs in cycle 3; grant 1 is given in cycle 4.
- 4 accepts with no commit_fire -> inflight=4 and alu_valid=0. Then commit_fire for one cycle -> inflight=3 and the next op issues. Simultaneous accept + commit_fire -> inflight unchanged.
- flush_req raised with inflight=3 and a locked grant -> alu_valid=0 and alu_flush_req=1 the same cycle. alu_flush_ack after 2 cycles -> flush_ack=1 next cycle, inflight=0, rr_ptr=0. flush_req low -> RUN, both acks clear.
- flush_req pulsed for 1 cycle, alu_flush_ack 3 cycles later -> stays in FLUSH_WAIT. Passes through FLUSH_DONE for one cycle with flush_ack=1, then returns to RUN.
- rst_core asserted in FLUSH_WAIT -> next cycle state=RUN and all outputs 0. A stale alu_flush_ack is ignored.

Source files
------------

// File: rtl/hsv_core_pkg.sv
// Shared core types: ALU op payload and the ALU issue arbiter FSM encoding.
package hsv_core_pkg;

  localparam int unsigned XLEN             = 32;
  localparam int unsigned ALU_OP_W         = 4;
  localparam int unsigned REG_IDX_W        = 5;
  localparam int unsigned ALU_MAX_INFLIGHT = 4;

  typedef struct packed {
    logic [ALU_OP_W-1:0]  op;
    logic [REG_IDX_W-1:0] rd;
    logic [XLEN-1:0]      src_a;
    logic [XLEN-1:0]      src_b;
  } alu_data_t;

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    FLUSH_WAIT = 2'd1,
    FLUSH_DONE = 2'd2
  } alu_arb_state_t;

endpackage

// File: rtl/hsv_core_alu_issue_arbiter_if.sv
// Issue-side requests, ALU input channel, flush handshakes and commit strobe
// seen by the ALU issue arbiter.
interface hsv_core_alu_issue_arbiter_if
  import hsv_core_pkg::*;
#(
  parameter int unsigned N_REQ        = 2,
  parameter int unsigned MAX_INFLIGHT = ALU_MAX_INFLIGHT
);

  localparam int unsigned GW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int unsigned IW = $clog2(MAX_INFLIGHT + 1);

  logic                        flush_req;
  logic                        flush_ack;
  alu_data_t [N_REQ-1:0]       req_data;
  logic      [N_REQ-1:0]       req_valid;
  logic      [N_REQ-1:0]       req_ready;
  alu_data_t                   alu_data;
  logic                        alu_valid;
  logic                        alu_ready;
  logic                        alu_flush_req;
  logic                        alu_flush_ack;
  logic                        commit_fire;
  logic      [GW-1:0]          grant_id;
  logic      [IW-1:0]          inflight;

  // Arbiter side
  modport slave (
    input  flush_req, req_data, req_valid, alu_ready, alu_flush_ack, commit_fire,
    output flush_ack, req_ready, alu_data, alu_valid, alu_flush_req, grant_id, inflight
  );

  // Environment side (issue stage + ALU)
  modport master (
    output flush_req, req_data, req_valid, alu_ready, alu_flush_ack, commit_fire,
    input  flush_ack, req_ready, alu_data, alu_valid, alu_flush_req, grant_id, inflight
  );

endinterface

// File: rtl/hsv_core_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr_i, with wrap.
module hsv_core_rr_pick #(
  parameter int unsigned N = 2
) (
  input  logic [N-1:0]                       req_i,
  input  logic [((N > 1) ? $clog2(N) : 1)-1:0] ptr_i,
  output logic [((N > 1) ? $clog2(N) : 1)-1:0] grant_o,
  output logic                               any_o
);

  localparam int unsigned W = (N > 1) ? $clog2(N) : 1;

  logic [W-1:0] idx;
  int unsigned  pos;

  always_comb begin
    grant_o = ptr_i;
    any_o   = 1'b0;
    idx     = '0;
    pos     = 0;
    for (int unsigned k = 0; k < N; k++) begin
      pos = 32'(ptr_i) + k;
      if (pos >= N) pos = pos - N;
      idx = W'(pos);
      if (!any_o && req_i[idx]) begin
        any_o   = 1'b1;
        grant_o = idx;
      end
    end
  end

endmodule

// File: rtl/hsv_core_alu_issue_arbiter.sv
// Round-robin, grant-locking arbiter sharing the ALU between issue requesters,
// with in-flight throttling and a non-abortable flush handshake to the ALU.
module hsv_core_alu_issue_arbiter
  import hsv_core_pkg::*;
#(
  parameter int unsigned N_REQ        = 2,
  parameter int unsigned MAX_INFLIGHT = ALU_MAX_INFLIGHT
) (
  input logic                   clk_core,
  input logic                   rst_core,
  hsv_core_alu_issue_arbiter_if.slave bus
);

  localparam int unsigned GW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int unsigned IW = $clog2(MAX_INFLIGHT + 1);

  alu_arb_state_t   state_q, state_d;
  logic [GW-1:0]    rr_ptr_q, rr_ptr_d;
  logic [GW-1:0]    locked_id_q, locked_id_d;
  logic             lock_q, lock_d;
  logic [IW-1:0]    inflight_q, inflight_d;

  logic [GW-1:0]    pick_idx;
  logic             pick_any;
  logic [GW-1:0]    grant;
  logic             grant_valid;
  logic             can_issue;
  logic             commit_ok;
  logic             accept;
  logic             alu_valid_c;
  logic [N_REQ-1:0] req_ready_c;
  logic             flush_ack_c;
  logic             alu_flush_req_c;

  hsv_core_rr_pick #(.N(N_REQ)) u_pick (
    .req_i   (bus.req_valid),
    .ptr_i   (rr_ptr_q),
    .grant_o (pick_idx),
    .any_o   (pick_any)
  );

  // A locked grant holds until accepted, regardless of newly valid requesters.
  assign grant       = lock_q ? locked_id_q : pick_idx;
  assign grant_valid = lock_q ? bus.req_valid[locked_id_q] : pick_any;
  assign can_issue   = (inflight_q < IW'(MAX_INFLIGHT));
  assign commit_ok   = bus.commit_fire & (inflight_q != '0);

  always_ff @(posedge clk_core) begin
    if (rst_core) begin
      state_q     <= RUN;
      rr_ptr_q    <= '0;
      locked_id_q <= '0;
      lock_q      <= 1'b0;
      inflight_q  <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      locked_id_q <= locked_id_d;
      lock_q      <= lock_d;
      inflight_q  <= inflight_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    rr_ptr_d        = rr_ptr_q;
    locked_id_d     = locked_id_q;
    lock_d          = lock_q;
    inflight_d      = inflight_q;
    accept          = 1'b0;
    alu_valid_c     = 1'b0;
    req_ready_c     = '0;
    flush_ack_c     = 1'b0;
    alu_flush_req_c = 1'b0;

    case (state_q)
      RUN: begin
        if (bus.flush_req) begin
          // Flush wins over any same-cycle issue.
          alu_flush_req_c = 1'b1;
          state_d         = FLUSH_WAIT;
        end else begin
          alu_valid_c        = can_issue & grant_valid;
          req_ready_c[grant] = can_issue & bus.alu_ready;
          accept             = alu_valid_c & bus.alu_ready;
          if (accept) begin
            rr_ptr_d = (grant == GW'(N_REQ - 1)) ? '0 : grant + GW'(1);
            lock_d   = 1'b0;
          end else if (alu_valid_c) begin
            lock_d      = 1'b1;
            locked_id_d = grant;
          end
        end
        case ({accept, commit_ok})
          2'b10:   inflight_d = inflight_q + IW'(1);
          2'b01:   inflight_d = inflight_q - IW'(1);
          default: inflight_d = inflight_q;
        endcase
      end

      FLUSH_WAIT: begin
        alu_flush_req_c = 1'b1;
        lock_d          = 1'b0;
        if (bus.alu_flush_ack) begin
          state_d    = FLUSH_DONE;
          inflight_d = '0;
          rr_ptr_d   = '0;
        end
      end

      FLUSH_DONE: begin
        flush_ack_c     = 1'b1;
        alu_flush_req_c = bus.flush_req;
        inflight_d      = '0;
        rr_ptr_d        = '0;
        if (!bus.flush_req) state_d = RUN;
      end

      default: state_d = RUN;
    endcase
  end

  assign bus.alu_valid     = alu_valid_c;
  assign bus.alu_data      = bus.req_data[grant];
  assign bus.req_ready     = req_ready_c;
  assign bus.flush_ack     = flush_ack_c;
  assign bus.alu_flush_req = alu_flush_req_c;
  assign bus.grant_id      = grant;
  assign bus.inflight      = inflight_q;

  a_no_commit_underflow: assert property (
    @(posedge clk_core) disable iff (rst_core)
    (state_q == RUN && bus.commit_fire) |-> (inflight_q != '0));

  a_inflight_cap: assert property (
    @(posedge clk_core) disable iff (rst_core)
    inflight_q <= IW'(MAX_INFLIGHT));

endmodule
